fft_reorder: RTL
================

FFT_REORDER -- requirements
Module: fft_reorder

Interface
REQ-001 Parameter: N, default 3, log2 of frame length (frame = 2^N complex samples).
REQ-002 Parameter: W, default 16, signed two's-complement width of each real/imag component.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  reset, synchronous, active-low.
REQ-005 Port: in_valid  input  1  upstream R2SDF stage presents a sample.
REQ-006 Port: in_ready  output  1  block can accept a sample this cycle.
REQ-007 Port: in_re, in_im  input  W each  sample from the butterfly pipeline, bit-reversed frame order.
REQ-008 Port: out_valid  output  1  natural-order sample available.
REQ-009 Port: out_ready  input  1  downstream accepts the sample.
REQ-010 Port: out_re, out_im  output  W each  sample in natural order.
REQ-011 Port: out_last  output  1  high with the final sample (index 2^N-1) of a frame.

Function
REQ-012 Storage SHALL be two banks (ping-pong) of 2^N entries, each entry {re, im}.
REQ-013 Input transfer SHALL occur when in_valid && in_ready; the sample is written to the write bank at address bitrev_N(wcnt), and wcnt (N bits) increments, wrapping to 0.
REQ-014 On the transfer with wcnt == 2^N-1, the write bank SHALL be marked full and the write pointer SHALL toggle to the other bank.
REQ-015 in_ready SHALL equal NOT full[wr_bank]; in_valid while in_ready is low is ignored without side effects.
REQ-016 out_valid SHALL equal full[rd_bank]; out_re/out_im SHALL be read combinationally from bank rd_bank at address rcnt.
REQ-017 Output transfer SHALL occur when out_valid && out_ready; rcnt increments and wraps; out_last = out_valid && (rcnt == 2^N-1).
REQ-018 On the transfer with out_last high, full[rd_bank] SHALL clear and rd_bank SHALL toggle.
REQ-019 Latency: out_valid SHALL rise in the cycle following the clock edge that accepts input index 2^N-1.
REQ-020 A bank freed by the final read SHALL become writable from the next cycle, not the same cycle; simultaneous last-write to one bank and last-read from the other SHALL both take effect.
REQ-021 With out_ready held high and continuous in_valid, throughput SHALL be one sample per cycle with in_ready never deasserting.
REQ-022 out_valid, out_re, out_im and out_last SHALL hold stable while out_valid && !out_ready.

Reset
REQ-023 While rst_n is low at a clock edge: wcnt, rcnt, wr_bank, rd_bank and both full flags SHALL reset to 0; bank contents are not cleared.
REQ-024 After reset: in_ready = 1, out_valid = 0, out_last = 0; out_re/out_im are don't-care while out_valid is 0.
REQ-025 Reset mid-frame SHALL discard partial and pending frames; the next accepted sample is index 0 of a new frame.

Configuration
REQ-026 Macro FFT_REORDER_STAT_EN: when defined, an extra output port frame_cnt (16 bits) SHALL count completed output frames, incrementing on each out_last transfer, wrapping at 2^16, reset to 0.
REQ-027 When FFT_REORDER_STAT_EN is undefined, frame_cnt and its counter SHALL not exist; all other behaviour is identical.

Structure
REQ-028 A shared package SHALL hold the bit-reverse function bitrev(value, N) and the complex sample struct {re, im}, for reuse by the butterfly stage and shuffle-index generator.
REQ-029 One sub-module, fft_reorder_bank (2^N-entry register file, one write port, one async read port), SHALL be instantiated twice.

Verification
REQ-030 N=3, out_ready=1, inputs re=0..7 on consecutive cycles -> out_re sequence 0,4,2,6,1,5,3,7; out_last on the 8th output; first out_valid one cycle after the 8th input.
REQ-031 Two back-to-back frames, out_ready=1 -> in_ready stays 1 throughout; second frame emitted immediately after the first with no bubble.
REQ-032 out_ready=0, three frames offered -> two frames accepted, in_ready low from the cycle after the 16th input; the third frame's first sample is accepted once out_ready rises and the first frame drains.
REQ-033 out_ready toggling 1,0,1,0 mid-frame -> output data held during stalls; order unchanged; no sample lost or duplicated.
REQ-034 rst_n low for one cycle after 5 of 8 inputs -> out_valid stays 0; a following full frame emerges correctly reordered.
REQ-035 FFT_REORDER_STAT_EN defined, 3 frames drained -> frame_cnt = 3; undefined build compiles without the port.

Source files
------------

// File: rtl/fft_reorder_pkg.sv
// fft_reorder_pkg: shared bit-reverse helper and complex sample type for the FFT datapath
package fft_reorder_pkg;

  localparam int CPLX_W = 16;

  typedef struct packed {
    logic signed [CPLX_W-1:0] re;
    logic signed [CPLX_W-1:0] im;
  } cplx_t;

  // Reverse the low n bits of v; upper bits of the result are zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int n);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[n-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: 2^N-entry register file, one sync write port, one async read port
module fft_reorder_bank #(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           we,
  input  logic [N-1:0]   waddr,
  input  logic [2*W-1:0] wdata,
  input  logic [N-1:0]   raddr,
  output logic [2*W-1:0] rdata
);

  logic [2*W-1:0] mem [2**N];

  // Storage is intentionally not reset; validity is tracked by the owner.
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];

endmodule

// File: rtl/fft_reorder.sv
// fft_reorder: ping-pong bit-reversed to natural order reorder buffer; FFT_REORDER_STAT_EN adds frame_cnt
module fft_reorder
  import fft_reorder_pkg::*;
#(
  parameter int N = 3,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_re,
  input  logic [W-1:0] in_im,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_re,
  output logic [W-1:0] out_im,
  output logic         out_last
`ifdef FFT_REORDER_STAT_EN
  , output logic [15:0] frame_cnt
`endif
);

  localparam logic [N-1:0] LAST = {N{1'b1}};

  logic [N-1:0]   wcnt, rcnt, waddr;
  logic           wr_bank, rd_bank;
  logic [1:0]     full, full_nxt;
  logic           in_fire, out_fire, wlast, rlast;
  logic [2*W-1:0] rdata0, rdata1;

  assign in_ready  = !full[wr_bank];
  assign out_valid = full[rd_bank];
  assign out_last  = out_valid && (rcnt == LAST);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign wlast     = in_fire && (wcnt == LAST);
  assign rlast     = out_fire && out_last;
  assign waddr     = N'(bitrev(32'(wcnt), N));
  assign {out_re, out_im} = rd_bank ? rdata1 : rdata0;

  fft_reorder_bank #(.N(N), .W(W)) u_bank0 (
    .clk(clk), .we(in_fire && !wr_bank), .waddr(waddr), .wdata({in_re, in_im}),
    .raddr(rcnt), .rdata(rdata0)
  );

  fft_reorder_bank #(.N(N), .W(W)) u_bank1 (
    .clk(clk), .we(in_fire && wr_bank), .waddr(waddr), .wdata({in_re, in_im}),
    .raddr(rcnt), .rdata(rdata1)
  );

  // Set the bank just filled, clear the bank just drained; they are never the same bank.
  always_comb begin
    full_nxt = full;
    if (wlast) full_nxt[wr_bank] = 1'b1;
    if (rlast) full_nxt[rd_bank] = 1'b0;
  end

  // Counters, bank pointers and full flags.
  always_ff @(posedge clk)
    if (!rst_n) begin
      wcnt    <= '0;
      rcnt    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (in_fire) wcnt <= wcnt + 1'b1;
      if (out_fire) rcnt <= rcnt + 1'b1;
      if (wlast) wr_bank <= !wr_bank;
      if (rlast) rd_bank <= !rd_bank;
      full <= full_nxt;
    end

`ifdef FFT_REORDER_STAT_EN
  // Count frames fully delivered downstream.
  always_ff @(posedge clk)
    if (!rst_n) frame_cnt <= '0;
    else if (rlast) frame_cnt <= frame_cnt + 16'd1;
`endif

endmodule
